// File: rtl/reset_sequencer.sv
// reset_sequencer: orders clock lock, DDR calibration, peripheral and core reset release
// Revision: 1.0
`default_nettype none

module reset_sequencer #(
  parameter int unsigned HoldCycles   = 64,
  parameter int unsigned CoreDelay    = 16,
  parameter int unsigned NdmMinCycles = 8,
  parameter int unsigned CalibTimeout = 2**20
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       locked_i,
  input  logic       calib_done_i,
  input  logic       ndmreset_ni,
  output logic       rst_periph_no,
  output logic       rst_core_no,
  output logic       ready_o,
  output logic       calib_timeout_o,
  output logic [2:0] state_o
);

  localparam int unsigned CNT_W = (CalibTimeout > 32'd65536) ? 24 : 16;
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HoldCycles - 1);
  localparam logic [CNT_W-1:0] CORE_LAST  = CNT_W'(CoreDelay - 1);
  localparam logic [CNT_W-1:0] NDM_LAST   = CNT_W'(NdmMinCycles - 1);
  localparam logic [CNT_W-1:0] CALIB_LAST = CNT_W'(CalibTimeout - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    WAIT_CALIB = 3'd1,
    HOLD       = 3'd2,
    PERIPH     = 3'd3,
    RUN        = 3'd4,
    NDM        = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             locked_m;
  logic             locked_s;
  logic             calib_m;
  logic             calib_s;
  logic             counting;
  logic             calib_needed;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
      calib_m  <= 1'b0;
      calib_s  <= 1'b0;
    end else begin
      locked_m <= locked_i;
      locked_s <= locked_m;
      calib_m  <= calib_done_i;
      calib_s  <= calib_m;
    end
  end

  always_comb begin
    counting     = (state == WAIT_CALIB) || (state == HOLD) ||
                   (state == PERIPH) || (state == NDM);
    calib_needed = (state == HOLD) || (state == PERIPH) ||
                   (state == RUN) || (state == NDM);
  end

  // Abort conditions are tested first so they always win over normal progress.
  always_comb begin
    state_nxt = state;
    if (state != WAIT_LOCK && !locked_s) begin
      state_nxt = WAIT_LOCK;
    end else if (calib_needed && !calib_s) begin
      state_nxt = WAIT_CALIB;
    end else begin
      case (state)
        WAIT_LOCK:  if (locked_s) state_nxt = WAIT_CALIB;
        WAIT_CALIB: if (calib_s) state_nxt = HOLD;
        HOLD:       if (cnt == HOLD_LAST) state_nxt = PERIPH;
        PERIPH:     if (cnt == CORE_LAST) state_nxt = RUN;
        RUN:        if (!ndmreset_ni) state_nxt = NDM;
        NDM:        if (cnt >= NDM_LAST && ndmreset_ni) state_nxt = RUN;
        default:    state_nxt = WAIT_LOCK;
      endcase
    end
  end

  // Outputs are registered from the next state so they change with the state flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= WAIT_LOCK;
      cnt             <= '0;
      rst_periph_no   <= 1'b0;
      rst_core_no     <= 1'b0;
      ready_o         <= 1'b0;
      calib_timeout_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (counting && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (state == WAIT_CALIB && cnt == CALIB_LAST) begin
        calib_timeout_o <= 1'b1;
      end
      rst_periph_no <= (state_nxt == PERIPH) || (state_nxt == RUN) || (state_nxt == NDM);
      rst_core_no   <= (state_nxt == RUN);
      ready_o       <= (state_nxt == RUN);
    end
  end

  assign state_o = state;

endmodule

`default_nettype wire
